// File: rtl/ball_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ball_pkg
//  Description : Shared types and constants for the breakout ball engine:
//                frame FSM state encoding, coordinate widths, default
//                screen size and the erase colour.
//  Revision    : 1.0 - initial release
// ============================================================================
package ball_pkg;

    // Coordinate and offset widths
    localparam int X_W   = 8;
    localparam int Y_W   = 7;
    localparam int OFS_W = 3;

    // Default screen geometry
    localparam int SCR_W_DEF = 160;
    localparam int SCR_H_DEF = 120;

    // Background colour used when erasing the old sprite
    localparam logic [2:0] COLOUR_BLACK = 3'b000;

    // Frame sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ERASE  = 3'd1,
        UPDATE = 3'd2,
        DRAW   = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ball_if.sv
`default_nettype none
// ============================================================================
//  Module      : ball_if
//  Description : Bundle between the sprite controller (master) and the ball
//                engine (slave): frame request, collision events, pixel
//                plot stream and ball state read-back.
//  Revision    : 1.0 - initial release
// ============================================================================
interface ball_if;
    import ball_pkg::*;

    // Controller -> engine
    logic             start;
    logic [2:0]       colour_in;
    logic             paddle_collision;
    logic             h_bounce;
    logic             v_bounce;

    // Engine -> controller / VGA
    logic [X_W-1:0]   x;
    logic [Y_W-1:0]   y;
    logic [2:0]       colour;
    logic             plot;
    logic             done;
    logic             miss;
    logic [X_W-1:0]   ball_x_top;
    logic [Y_W-1:0]   ball_y_top;
    logic             h_q;
    logic             v_q;

    modport master (
        output start, colour_in, paddle_collision, h_bounce, v_bounce,
        input  x, y, colour, plot, done, miss, ball_x_top, ball_y_top, h_q, v_q
    );

    modport slave (
        input  start, colour_in, paddle_collision, h_bounce, v_bounce,
        output x, y, colour, plot, done, miss, ball_x_top, ball_y_top, h_q, v_q
    );

endinterface
`default_nettype wire

// File: rtl/ball_engine_sprite_raster.sv
`default_nettype none
// ============================================================================
//  Module      : sprite_raster
//  Description : Row-major offset scanner over a BALL_W x BALL_H sprite.
//                dx is the fast index. Advances on enable, wraps to (0,0)
//                after the last pixel; last flags the final offset.
//  Revision    : 1.0 - initial release
// ============================================================================
module sprite_raster
    import ball_pkg::*;
#(
    parameter int BALL_W = 3,
    parameter int BALL_H = 3
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             clear,
    input  wire logic             enable,
    output logic [OFS_W-1:0]      dx,
    output logic [OFS_W-1:0]      dy,
    output logic                  last
);

    localparam logic [OFS_W-1:0] DX_END = OFS_W'(BALL_W - 1);
    localparam logic [OFS_W-1:0] DY_END = OFS_W'(BALL_H - 1);

    logic row_end;

    // Decode end of row and end of sprite from the current offset
    always_comb begin
        row_end = (dx == DX_END);
        last    = row_end && (dy == DY_END);
    end

    // Offset counter: dx fast, dy slow, wrap to origin after the last pixel
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dx <= '0;
            dy <= '0;
        end else if (clear) begin
            dx <= '0;
            dy <= '0;
        end else if (enable) begin
            if (row_end) begin
                dx <= '0;
                dy <= last ? '0 : dy + 1'b1;
            end else begin
                dx <= dx + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
//  Module      : ball_engine
//  Description : Breakout ball. Each start request runs one frame: erase the
//                sprite at the old position, move with wall/brick/paddle
//                bounce, draw at the new position, pulse done (and miss when
//                the ball fell past the bottom wall).
//  Options     : BALL_SPEEDUP_EN - every 4th paddle hit raises the step by
//                one (up to STEP_MAX); a miss restores the base step.
//  Revision    : 1.0 - initial release
// ============================================================================
module ball_engine
    import ball_pkg::*;
#(
    parameter int BALL_W   = 3,
    parameter int BALL_H   = 3,
    parameter int SCR_W    = SCR_W_DEF,
    parameter int SCR_H    = SCR_H_DEF,
    parameter int X0       = 78,
    parameter int Y0       = 58,
    parameter int STEP     = 1,
    parameter int STEP_MAX = 4
) (
    input  wire logic clock,
    input  wire logic reset,
    ball_if.slave     bus
);

    // The ceiling also bounds the base speed so a misconfigured pair stays sane
    localparam int STEP_BASE = (STEP < STEP_MAX) ? STEP : STEP_MAX;

    localparam logic signed [X_W:0] X_MAX = (X_W + 1)'(SCR_W - BALL_W);
    localparam logic signed [Y_W:0] Y_MAX = (Y_W + 1)'(SCR_H - BALL_H);

    state_t state, state_next;

    logic [X_W-1:0]   pos_x;
    logic [Y_W-1:0]   pos_y;
    logic             h_dir;
    logic             v_dir;
    logic [2:0]       step;

    logic             lat_pc, lat_hb, lat_vb;
    logic             pass_end;
    logic             miss_pend;

    logic             emit;
    logic             raster_clear;
    logic [OFS_W-1:0] dx, dy;
    logic             raster_last;

    // Next-position results, valid in UPDATE
    logic             eff_pc, eff_hb, eff_vb;
    logic             h_pre, v_pre;
    logic signed [X_W:0] nx_s;
    logic signed [Y_W:0] ny_s;
    logic [X_W-1:0]   upd_x;
    logic [Y_W-1:0]   upd_y;
    logic             upd_h, upd_v, upd_miss;

    logic [X_W-1:0]   base_x, pix_x;
    logic [Y_W-1:0]   base_y, pix_y;

    sprite_raster #(
        .BALL_W (BALL_W),
        .BALL_H (BALL_H)
    ) u_raster (
        .clock  (clock),
        .reset  (reset),
        .clear  (raster_clear),
        .enable (emit),
        .dx     (dx),
        .dy     (dy),
        .last   (raster_last)
    );

    // Frame state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state; emit marks edges that load a pixel into the plot registers
    always_comb begin
        state_next   = state;
        emit         = 1'b0;
        raster_clear = 1'b0;
        case (state)
            IDLE: begin
                raster_clear = !bus.start;
                if (bus.start) begin
                    state_next = ERASE;
                    emit       = 1'b1;
                end
            end
            ERASE: begin
                if (pass_end) begin
                    state_next = UPDATE;
                end else begin
                    emit = 1'b1;
                end
            end
            UPDATE: begin
                state_next = DRAW;
                emit       = 1'b1;
            end
            DRAW: begin
                if (pass_end) begin
                    state_next = DONE;
                end else begin
                    emit = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Movement: a collision arriving in the UPDATE cycle itself still counts
    always_comb begin
        eff_pc   = lat_pc | bus.paddle_collision;
        eff_hb   = lat_hb | bus.h_bounce;
        eff_vb   = lat_vb | bus.v_bounce;

        h_pre    = h_dir ^ eff_hb;
        v_pre    = eff_pc ? 1'b0 : (v_dir ^ eff_vb);

        nx_s     = h_pre ? ($signed({1'b0, pos_x}) + $signed({6'b0, step}))
                         : ($signed({1'b0, pos_x}) - $signed({6'b0, step}));
        ny_s     = v_pre ? ($signed({1'b0, pos_y}) + $signed({5'b0, step}))
                         : ($signed({1'b0, pos_y}) - $signed({5'b0, step}));

        upd_x    = nx_s[X_W-1:0];
        upd_h    = h_pre;
        upd_y    = ny_s[Y_W-1:0];
        upd_v    = v_pre;
        upd_miss = 1'b0;

        if (nx_s < 0) begin
            upd_x = '0;
            upd_h = ~h_pre;
        end else if (nx_s > X_MAX) begin
            upd_x = X_MAX[X_W-1:0];
            upd_h = ~h_pre;
        end

        if (ny_s < 0) begin
            upd_y = '0;
            upd_v = 1'b1;
        end else if (ny_s > Y_MAX) begin
            // Fell past the bottom: respawn overrides the horizontal result
            upd_x    = X_W'(X0);
            upd_y    = Y_W'(Y0);
            upd_h    = 1'b1;
            upd_v    = 1'b0;
            upd_miss = 1'b1;
        end
    end

    // Pixel address: the first draw pixel is loaded in UPDATE from the new position
    always_comb begin
        base_x = (state == UPDATE) ? upd_x : pos_x;
        base_y = (state == UPDATE) ? upd_y : pos_y;
        pix_x  = base_x + {{(X_W - OFS_W){1'b0}}, dx};
        pix_y  = base_y + {{(Y_W - OFS_W){1'b0}}, dy};
    end

    // Ball position and direction, committed at the end of UPDATE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos_x     <= X_W'(X0);
            pos_y     <= Y_W'(Y0);
            h_dir     <= 1'b1;
            v_dir     <= 1'b0;
            miss_pend <= 1'b0;
        end else if (state == UPDATE) begin
            pos_x     <= upd_x;
            pos_y     <= upd_y;
            h_dir     <= upd_h;
            v_dir     <= upd_v;
            miss_pend <= upd_miss;
        end else if (state == DONE) begin
            miss_pend <= 1'b0;
        end
    end

    // Collision latches: capture outside IDLE, clear after UPDATE consumes them
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            lat_pc <= 1'b0;
            lat_hb <= 1'b0;
            lat_vb <= 1'b0;
        end else if (state == UPDATE) begin
            lat_pc <= 1'b0;
            lat_hb <= 1'b0;
            lat_vb <= 1'b0;
        end else if (state != IDLE) begin
            lat_pc <= lat_pc | bus.paddle_collision;
            lat_hb <= lat_hb | bus.h_bounce;
            lat_vb <= lat_vb | bus.v_bounce;
        end
    end

`ifdef BALL_SPEEDUP_EN
    logic [1:0] hits;

    // Speed-up: every 4th paddle hit adds one to the step; a miss resets it
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            step <= 3'(STEP_BASE);
            hits <= 2'd0;
        end else if (state == UPDATE) begin
            if (upd_miss) begin
                step <= 3'(STEP_BASE);
                hits <= 2'd0;
            end else if (eff_pc) begin
                hits <= hits + 2'd1;
                if ((hits == 2'd3) && (step < 3'(STEP_MAX))) begin
                    step <= step + 3'd1;
                end
            end
        end
    end
`else
    assign step = 3'(STEP_BASE);
`endif

    // Pass end flag: the last pixel of a pass was loaded on the previous edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pass_end <= 1'b0;
        end else begin
            pass_end <= emit & raster_last;
        end
    end

    // Plot stream registers, aligned with plot
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.x      <= '0;
            bus.y      <= '0;
            bus.colour <= COLOUR_BLACK;
            bus.plot   <= 1'b0;
        end else if (emit) begin
            bus.x      <= pix_x;
            bus.y      <= pix_y;
            bus.colour <= ((state == IDLE) || (state == ERASE)) ? COLOUR_BLACK
                                                                 : bus.colour_in;
            bus.plot   <= 1'b1;
        end else begin
            bus.plot   <= 1'b0;
        end
    end

    // Frame-complete and miss pulses, issued as DRAW hands over to DONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.done <= 1'b0;
            bus.miss <= 1'b0;
        end else begin
            bus.done <= (state == DRAW) && pass_end;
            bus.miss <= (state == DRAW) && pass_end && miss_pend;
        end
    end

    // Ball state read-back
    always_comb begin
        bus.ball_x_top = pos_x;
        bus.ball_y_top = pos_y;
        bus.h_q        = h_dir;
        bus.v_q        = v_dir;
    end

endmodule
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ball_engine
//  Description : Directed self-checking bench for ball_engine with default
//                parameters (3x3 sprite, 160x120 screen, spawn 78,58, step 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_engine;
    import ball_pkg::*;

    localparam int         BW  = 3;
    localparam int         N   = 9;
    localparam logic [2:0] COL = 3'b101;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    ball_if bus();

    ball_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One frame from IDLE: old top-left (ex,ey) -> new (nx,ny) with directions nh/nv.
    // Collision pulses are driven during cycle 2 (ERASE).
    task automatic frame(input int ex, input int ey, input int nx, input int ny,
                         input bit nh, input bit nv,
                         input bit pc, input bit hb, input bit vb,
                         input bit exp_miss, input bit detail);
        int idx;
        chk("pre_x", bus.ball_x_top, ex);
        chk("pre_y", bus.ball_y_top, ey);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 2*N+2; c++) begin
            bus.paddle_collision = pc && (c == 2);
            bus.h_bounce         = hb && (c == 2);
            bus.v_bounce         = vb && (c == 2);
            if (detail) begin
                if (c <= N) begin
                    idx = c - 1;
                    chk("erase_plot",   bus.plot,   1);
                    chk("erase_x",      bus.x,      ex + idx % BW);
                    chk("erase_y",      bus.y,      ey + idx / BW);
                    chk("erase_colour", bus.colour, 0);
                end else if (c == N+1) begin
                    chk("update_plot", bus.plot, 0);
                end else if (c <= 2*N+1) begin
                    idx = c - N - 2;
                    chk("draw_plot",   bus.plot,   1);
                    chk("draw_x",      bus.x,      nx + idx % BW);
                    chk("draw_y",      bus.y,      ny + idx / BW);
                    chk("draw_colour", bus.colour, COL);
                end else begin
                    chk("done_plot", bus.plot, 0);
                end
                if (c != 2*N+2) chk("done_early", bus.done, 0);
            end
            if (c == 2*N+2) begin
                chk("done_pulse", bus.done, 1);
                chk("miss_pulse", bus.miss, exp_miss);
            end
            tick();
        end
        bus.paddle_collision = 1'b0;
        bus.h_bounce         = 1'b0;
        bus.v_bounce         = 1'b0;
        chk("done_low", bus.done, 0);
        chk("post_x", bus.ball_x_top, nx);
        chk("post_y", bus.ball_y_top, ny);
        chk("post_h", bus.h_q, nh);
        chk("post_v", bus.v_q, nv);
    endtask

    initial begin
        int dones;
        bus.start            = 1'b0;
        bus.colour_in        = COL;
        bus.paddle_collision = 1'b0;
        bus.h_bounce         = 1'b0;
        bus.v_bounce         = 1'b0;

        // Reset state
        tick(); tick(); tick();
        chk("rst_x",      bus.x,      0);
        chk("rst_y",      bus.y,      0);
        chk("rst_colour", bus.colour, 0);
        chk("rst_plot",   bus.plot,   0);
        chk("rst_done",   bus.done,   0);
        chk("rst_miss",   bus.miss,   0);
        chk("rst_bx",     bus.ball_x_top, 78);
        chk("rst_by",     bus.ball_y_top, 58);
        chk("rst_h",      bus.h_q,    1);
        chk("rst_v",      bus.v_q,    0);
        reset = 1'b0;
        tick();

        // First frame, full raster check
        frame(78, 58, 79, 57, 1, 0, 0, 0, 0, 0, 1);
        // Paddle and v_bounce together: paddle wins, ball keeps going up
        frame(79, 57, 80, 56, 1, 0, 1, 0, 1, 0, 0);
        // v_bounce alone flips to downward
        frame(80, 56, 81, 57, 1, 1, 0, 0, 1, 0, 0);
        // h_bounce flips to leftward
        frame(81, 57, 80, 58, 0, 1, 0, 1, 0, 0, 0);
        // Down-left to y=117
        for (int k = 1; k <= 59; k++)
            frame(81-k, 57+k, 80-k, 58+k, 0, 1, 0, 0, 0, 0, 0);
        // Bottom wall: respawn with miss
        frame(21, 117, 78, 58, 1, 0, 0, 0, 0, 1, 1);
        // Up-right to the top wall
        for (int k = 1; k <= 58; k++)
            frame(77+k, 59-k, 78+k, 58-k, 1, 0, 0, 0, 0, 0, 0);
        // Top wall: clamp y to 0 and turn downward
        frame(136, 0, 137, 0, 1, 1, 0, 0, 0, 0, 0);
        for (int k = 60; k <= 79; k++)
            frame(77+k, k-60, 78+k, k-59, 1, 1, 0, 0, 0, 0, 0);
        // Right wall: x stays at 157, direction turns
        frame(157, 20, 157, 21, 0, 1, 0, 0, 0, 0, 1);

        // Reset during DRAW (cycle 14), with a stray start at cycle 5
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            bus.start = (c == 5);
            tick();
        end
        bus.start = 1'b0;
        chk("mid_plot",   bus.plot,   1);
        chk("mid_x",      bus.x,      156);
        chk("mid_y",      bus.y,      23);
        chk("mid_colour", bus.colour, COL);
        reset = 1'b1;
        #1;
        chk("arst_plot", bus.plot,       0);
        chk("arst_bx",   bus.ball_x_top, 78);
        chk("arst_by",   bus.ball_y_top, 58);
        chk("arst_h",    bus.h_q,        1);
        chk("arst_v",    bus.v_q,        0);
        tick(); tick();
        reset = 1'b0;
        dones = 0;
        repeat (30) begin
            tick();
            if (bus.done) dones++;
        end
        chk("no_done_after_reset", dones, 0);

        // h_bounce in IDLE is dropped
        bus.h_bounce = 1'b1;
        tick();
        bus.h_bounce = 1'b0;
        tick();
        frame(78, 58, 79, 57, 1, 0, 0, 0, 0, 0, 0);

`ifdef BALL_SPEEDUP_EN
        // Four paddle frames raise step to 2
        frame(79, 57, 80, 56, 1, 0, 1, 0, 0, 0, 0);
        frame(80, 56, 81, 55, 1, 0, 1, 0, 0, 0, 0);
        frame(81, 55, 82, 54, 1, 0, 1, 0, 0, 0, 0);
        frame(82, 54, 83, 53, 1, 0, 1, 0, 0, 0, 0);
        frame(83, 53, 85, 51, 1, 0, 0, 0, 0, 0, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ball_engine.md
# ball_engine

Parametrised successor to the single-size breakout ball. It owns ball position and direction, and on each `start` pulse from the sprite controller it runs one frame: erase the old sprite, move, draw the new sprite. Ball size, screen bounds, spawn point and step size are parameters. Wall bounce is handled internally, and the block reports a missed ball at the bottom wall.

## Interface
- `BALL_W`, 3: sprite width in pixels, 1..8
- `BALL_H`, 3: sprite height in pixels, 1..8
- `SCR_W`, 160: screen width; x range 0..SCR_W-1
- `SCR_H`, 120: screen height; y range 0..SCR_H-1
- `X0`, 78: spawn top-left x
- `Y0`, 58: spawn top-left y
- `STEP`, 1: pixels moved per frame on each axis, 1..4
- `STEP_MAX`, 4: speed ceiling; used only with `BALL_SPEEDUP_EN`

Ports:
- `clock`  in  1  single clock
- `reset`  in  1  asynchronous, active-high
- `start`  in  1  one-cycle frame request; ignored unless in IDLE
- `colour_in`  in  3  ball colour
- `paddle_collision`  in  1  paddle hit; forces direction up
- `h_bounce`  in  1  brick hit; toggles horizontal direction
- `v_bounce`  in  1  brick hit; toggles vertical direction
- `x`  out  8  plot x
- `y`  out  7  plot y
- `colour`  out  3  plot colour
- `plot`  out  1  VGA write enable
- `done`  out  1  one-cycle frame-complete pulse
- `miss`  out  1  one-cycle pulse, coincident with `done`, when the ball reached the bottom wall
- `ball_x_top`  out  8  current top-left x
- `ball_y_top`  out  7  current top-left y
- `h_q`  out  1  horizontal direction; 1 = +x
- `v_q`  out  1  vertical direction; 1 = +y (down)

## Operation
- FSM states: IDLE, ERASE, UPDATE, DRAW, DONE.
  - IDLE -> ERASE on `start`.
  - ERASE -> UPDATE after the last pixel.
  - UPDATE -> DRAW (one cycle).
  - DRAW -> DONE after the last pixel.
  - DONE -> IDLE (one cycle).
- Raster: offsets (dx, dy) scan row-major. dx runs 0..BALL_W-1 and is the fast index; dy runs 0..BALL_H-1. That gives N = BALL_W*BALL_H pixels.
  - Outputs: `x = ball_x_top + dx`, `y = ball_y_top + dy`.
- ERASE: `plot=1`, `colour=3'b000`, old position.
- DRAW: `plot=1`, `colour=colour_in`, new position.
- Collision latches: `paddle_collision`, `h_bounce` and `v_bounce` are captured in any cycle outside IDLE, including the UPDATE cycle itself. All three latches clear at the end of UPDATE. Pulses that arrive in IDLE are dropped.
- UPDATE, horizontal (s = current step):
  - Toggle `h_q` if `h_bounce` is latched.
  - Then, if the next x would fall outside 0..SCR_W-BALL_W, toggle `h_q` again and clamp x to the wall.
  - Otherwise x += s or x -= s according to `h_q`.
- UPDATE, vertical:
  - `paddle_collision` sets `v_q=0`. It takes priority; `v_bounce` is ignored in the same frame.
  - Else `v_bounce` toggles `v_q`.
  - Top wall: clamp y to 0 and set `v_q=1`.
  - Bottom wall (next y > SCR_H-BALL_H): respawn at (X0, Y0) with `h_q=1`, `v_q=0`, and set the `miss` flag for this frame.
- Arithmetic: use one-bit-wider signed intermediates for next x and y, so underflow below 0 is detected rather than wrapping.

## Timing
- Reset values:
  - Position (X0, Y0); `h_q=1`; `v_q=0`; step = STEP.
  - FSM in IDLE.
  - `x=0`, `y=0`, `colour=0`.
  - `plot=0`, `done=0`, `miss=0`.
  - All latches clear.
- Frame latency, with `start` sampled at cycle 0:
  - Erase pixels on cycles 1..N.
  - UPDATE on cycle N+1; `ball_x_top`/`ball_y_top` change at the end of this cycle.
  - Draw pixels on cycles N+2..2N+1.
  - `done` on cycle 2N+2.
  - Earliest next accepted `start`: cycle 2N+3.
- `plot` is registered and aligned with `x`/`y`/`colour`. It is low in IDLE, UPDATE and DONE.
- Reset asserted mid-frame: return to the reset state immediately; no `done` is produced.

## Configuration
- `BALL_SPEEDUP_EN` defined:
  - A 2-bit hit counter increments on each latched `paddle_collision` processed in UPDATE.
  - On wrap (every 4th hit), step increments, saturating at STEP_MAX.
  - A miss restores step to STEP and clears the counter.
- `BALL_SPEEDUP_EN` undefined: step is constant STEP; no counter exists; STEP_MAX is unused.

## Structure
- Package `ball_pkg` holds:
  - FSM state enum.
  - Default screen constants (160, 120).
  - `COLOUR_BLACK = 3'b000`.
  - Coordinate widths (8 and 7).
- Sub-module `sprite_raster`, parametrised by BALL_W and BALL_H:
  - Inputs: clear, enable.
  - Outputs: dx, dy, last.
  - Used for both the ERASE and DRAW passes.

## Test plan
- Reset, then `start`, with defaults: 9 erase pixels of colour 0 at (78..80, 58..60), then 9 draw pixels at (79..81, 57..59). `done` on cycle 20, `miss=0`.
- Ball at x=157, `h_q=1`, `start`: x clamps to 157 and `h_q` becomes 0.
- `paddle_collision` and `v_bounce` pulsed together during ERASE: after UPDATE `v_q=0` (up), single effect only.
- Ball at y=117, `v_q=1`, `start`: ball respawns at (78, 58) and `miss` pulses with `done`.
- `reset` asserted mid-DRAW at cycle 14: `plot` goes low at once, position returns to (78, 58), no `done`; a `start` issued during the frame is ignored.
- With `BALL_SPEEDUP_EN`: 4 paddle frames raise step to 2 (next move 2 px); a miss restores step to 1.
